// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver, mid-bit sampling, valid/ack output
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD   = 0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ack,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par_bit;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state;
    logic                  rx_meta, rx_s, rx_d;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_idx;
    logic                  stop_idx;
    logic                  stop_bad;
    logic [DATA_BITS-1:0]  shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_d       <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            stop_bad   <= 1'b0;
            shreg      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            rx_d      <= rx_s;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            // A load in the same cycle overrides this clear further down.
            if (dout_ack)
                dout_valid <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (en && rx_d && !rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == BIT_LAST) begin
                            stop_idx <= 1'b0;
                            stop_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            state    <= PARITY;
`else
                            state    <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (stop_idx == STOP_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (stop_bad || !rx_s) begin
                                frame_err <= 1'b1;
                            end else begin
                                dout       <= shreg;
                                dout_valid <= 1'b1;
                                overrun    <= dout_valid && !dout_ack;
`ifdef UART_RX_PARITY_EN
                                parity_err <= ((^shreg) ^ par_bit) != 1'(PARITY_ODD);
`endif
                            end
                        end else begin
                            stop_idx <= 1'b1;
                            stop_bad <= stop_bad || !rx_s;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
